// File: rtl/writeback_unit.sv
// Register-file write master: merges single-cycle ALU results with multi-cycle
// loads, formats load data, drops x0 writes and exports the pending load rd.
module writeback_unit #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [IDX_W-1:0]  alu_rd,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              load_req_valid,
   output logic              load_req_ready,
   input  logic [IDX_W-1:0]  load_rd,
   input  logic [2:0]        load_funct3,
   input  logic [1:0]        load_addr_lo,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              reg_write,
   output logic [IDX_W-1:0]  write_index,
   output logic [DATA_W-1:0] write_data,
   output logic              load_pending,
   output logic [IDX_W-1:0]  pending_rd,
   output logic              load_err,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_MEM   = 2'd1,
      WRITE_LOAD = 2'd2
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    ld_rd;
   logic [2:0]          ld_funct3;
   logic [1:0]          ld_addr_lo;
   logic [DATA_W-1:0]   hold_data;
   logic                req_legal;
   logic [7:0]          sel_byte;
   logic [15:0]         sel_half;
   logic [DATA_W-1:0]   fmt_data;

   // Handshake: a transfer happens on a rising edge where valid && ready; while
   // ready is low the producer keeps valid and its payload stable.
   assign alu_ready      = (state != WRITE_LOAD);
   assign load_req_ready = (state == IDLE);
   assign load_pending   = (state != IDLE);
   assign pending_rd     = load_pending ? ld_rd : '0;
   assign state_dbg      = state;

   always_comb begin
      req_legal = 1'b0;
      case (load_funct3)
         3'b000, 3'b100: req_legal = 1'b1;
         3'b001, 3'b101: req_legal = ~load_addr_lo[0];
         3'b010:         req_legal = (load_addr_lo == 2'b00);
         default:        req_legal = 1'b0;
      endcase
   end

   // Lanes are picked from the aligned word using the captured low address bits.
   always_comb begin
      sel_byte = 8'(mem_rdata >> {ld_addr_lo, 3'b000});
      sel_half = 16'(mem_rdata >> {ld_addr_lo[1], 4'b0000});
      case (ld_funct3)
         3'b000:  fmt_data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
         3'b001:  fmt_data = {{(DATA_W-16){sel_half[15]}}, sel_half};
         3'b100:  fmt_data = {{(DATA_W-8){1'b0}}, sel_byte};
         3'b101:  fmt_data = {{(DATA_W-16){1'b0}}, sel_half};
         default: fmt_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state       <= IDLE;
         ld_rd       <= '0;
         ld_funct3   <= '0;
         ld_addr_lo  <= '0;
         hold_data   <= '0;
         reg_write   <= 1'b0;
         write_index <= '0;
         write_data  <= '0;
         load_err    <= 1'b0;
      end else begin
         reg_write <= 1'b0;
         load_err  <= 1'b0;
         if (alu_valid && alu_ready) begin
            reg_write   <= (alu_rd != '0);
            write_index <= alu_rd;
            write_data  <= alu_result;
         end
         case (state)
            IDLE: begin
               if (load_req_valid) begin
                  if (req_legal) begin
                     ld_rd      <= load_rd;
                     ld_funct3  <= load_funct3;
                     ld_addr_lo <= load_addr_lo;
                     state      <= WAIT_MEM;
                  end else begin
                     load_err <= 1'b1;
                  end
               end
            end
            WAIT_MEM: begin
               if (mem_rvalid) begin
                  hold_data <= fmt_data;
                  state     <= WRITE_LOAD;
               end
            end
            WRITE_LOAD: begin
               // ALU is stalled this cycle, so the port belongs to the load.
               reg_write   <= (ld_rd != '0);
               write_index <= ld_rd;
               write_data  <= hold_data;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
